// File: rtl/fifo_sync.sv
// Single-clock FIFO with selectable registered or show-ahead read port,
// fill-level flags and sticky overflow/underflow indicators.
module fifo_sync #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 11,
    parameter int SHOWAHEAD = 0,
    parameter int AF_THRESH = (2 ** ADDR_BITS) - 16,
    parameter int AE_THRESH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     data,
    input  logic                 write,
    input  logic                 read,
    output logic [WIDTH-1:0]     q,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   usedw,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_C  = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   AF_C     = AF_THRESH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   AE_C     = AE_THRESH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   USED_ZERO = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0]   USED_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] PTR_ZERO  = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_r;
    logic [ADDR_BITS-1:0] rd_ptr_r;
    logic [ADDR_BITS:0]   usedw_r;
    logic [ADDR_BITS:0]   usedw_nxt_s;
    logic                 full_r;
    logic                 empty_r;
    logic                 af_r;
    logic                 ae_r;
    logic                 overflow_r;
    logic                 underflow_r;
    logic                 wr_acc_s;
    logic                 rd_acc_s;

    // Flags are a pure function of a fill level: {full, empty, almost_full, almost_empty}.
    function automatic logic [3:0] level_flags(input logic [ADDR_BITS:0] lvl);
        level_flags = {lvl == DEPTH_C, lvl == USED_ZERO, lvl >= AF_C, lvl <= AE_C};
    endfunction

    assign wr_acc_s = write & ~full_r;
    assign rd_acc_s = read & ~empty_r;

    // Next fill level from the accepted operations.
    always_comb begin
        usedw_nxt_s = usedw_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   usedw_nxt_s = usedw_r + USED_ONE;
            2'b01:   usedw_nxt_s = usedw_r - USED_ONE;
            default: usedw_nxt_s = usedw_r;
        endcase
    end

    // Pointers, fill level, registered flags and sticky error bits.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            usedw_r     <= USED_ZERO;
            {full_r, empty_r, af_r, ae_r} <= level_flags(USED_ZERO);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            usedw_r     <= usedw_nxt_s;
            {full_r, empty_r, af_r, ae_r} <= level_flags(usedw_nxt_s);
            overflow_r  <= overflow_r | (write & full_r);
            underflow_r <= underflow_r | (read & empty_r);
        end
    end

    // Storage array; no reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (wr_acc_s && !clear && !reset) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign q = mem_r[rd_ptr_r];
        end else begin : g_registered
            logic [WIDTH-1:0] q_r;

            // Read register: loaded only by an accepted read, held across clear.
            always_ff @(posedge clock) begin
                if (reset) begin
                    q_r <= {WIDTH{1'b0}};
                end else if (rd_acc_s && !clear) begin
                    q_r <= mem_r[rd_ptr_r];
                end
            end

            assign q = q_r;
        end
    endgenerate

    assign full         = full_r;
    assign empty        = empty_r;
    assign usedw        = usedw_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a registered-read and a show-ahead instance share stimulus and are
// compared against a queue-based reference model.
module tb_fifo_sync;
    logic        clock;
    logic        reset;
    logic        clear;
    logic        write;
    logic        read;
    logic [15:0] data;

    logic [15:0] q0, q1;
    logic        full0, empty0, af0, ae0, ovf0, unf0;
    logic        full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0]  usedw0, usedw1;
    logic [10:0] st0, st1;

    int total = 0;
    int bad   = 0;

    logic [15:0] mq [$];
    logic        m_ovf;
    logic        m_unf;
    logic [15:0] m_qreg;

    localparam logic [10:0] RESET_ST = 11'b0_1_0_1_0_0_00000;

    fifo_sync #(.WIDTH(16), .ADDR_BITS(4), .SHOWAHEAD(0), .AF_THRESH(12), .AE_THRESH(2)) u_reg (
        .clock(clock), .reset(reset), .clear(clear), .data(data), .write(write), .read(read),
        .q(q0), .full(full0), .empty(empty0), .usedw(usedw0), .almost_full(af0),
        .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_sync #(.WIDTH(16), .ADDR_BITS(4), .SHOWAHEAD(1), .AF_THRESH(12), .AE_THRESH(2)) u_fwft (
        .clock(clock), .reset(reset), .clear(clear), .data(data), .write(write), .read(read),
        .q(q1), .full(full1), .empty(empty1), .usedw(usedw1), .almost_full(af1),
        .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
    );

    assign st0 = {full0, empty0, af0, ae0, ovf0, unf0, usedw0};
    assign st1 = {full1, empty1, af1, ae1, ovf1, unf1, usedw1};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected status word derived from the model queue occupancy.
    function automatic logic [10:0] exp_status();
        int         sz;
        logic [4:0] u;
        sz = mq.size();
        u  = 5'(sz);
        return {sz == 16, sz == 0, sz >= 12, sz <= 2, m_ovf, m_unf, u};
    endfunction

    task automatic cyc(input logic w, input logic r, input logic [15:0] d,
                       input logic clr, input logic rst);
        logic wa, ra;
        write = w; read = r; data = d; clear = clr; reset = rst;
        @(posedge clock);
        wa = w && (mq.size() < 16);
        ra = r && (mq.size() > 0);
        if (rst) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_qreg = 16'h0000;
        end else if (clr) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            if (ra) m_qreg = mq.pop_front();
            if (wa) mq.push_back(d);
        end
        #1;
        write = 1'b0; read = 1'b0; clear = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        total++; if (st0 !== RESET_ST) begin bad++; $display("FAIL reset_st0 got=%b want=%b", st0, RESET_ST); end
        total++; if (st1 !== RESET_ST) begin bad++; $display("FAIL reset_st1 got=%b want=%b", st1, RESET_ST); end
        total++; if (q0 !== 16'h0000) begin bad++; $display("FAIL reset_q0 got=%h want=0000", q0); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
            total++; if (st0 !== exp_status()) begin bad++; $display("FAIL fill_st0[%0d] got=%b want=%b", i, st0, exp_status()); end
            total++; if (st1 !== exp_status()) begin bad++; $display("FAIL fill_st1[%0d] got=%b want=%b", i, st1, exp_status()); end
            total++; if (af0 !== (i >= 12)) begin bad++; $display("FAIL fill_af[%0d] got=%b want=%b", i, af0, (i >= 12)); end
            total++; if (ae0 !== (i <= 2)) begin bad++; $display("FAIL fill_ae[%0d] got=%b want=%b", i, ae0, (i <= 2)); end
        end
        total++; if (usedw0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b0) begin
            bad++; $display("FAIL fill_end got usedw=%0d full=%b ovf=%b want 16 1 0", usedw0, full0, ovf0);
        end
    endtask

    task automatic test_overflow();
        cyc(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
        total++; if (usedw0 !== 5'd16 || ovf0 !== 1'b1) begin
            bad++; $display("FAIL ovf_set got usedw=%0d ovf=%b want 16 1", usedw0, ovf0);
        end
        for (int i = 1; i <= 16; i++) begin
            total++; if (q1 !== 16'(i)) begin bad++; $display("FAIL drain_q1[%0d] got=%h want=%h", i, q1, 16'(i)); end
            cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
            total++; if (q0 !== 16'(i)) begin bad++; $display("FAIL drain_q0[%0d] got=%h want=%h", i, q0, 16'(i)); end
            total++; if (st0 !== exp_status()) begin bad++; $display("FAIL drain_st0[%0d] got=%b want=%b", i, st0, exp_status()); end
        end
        total++; if (empty0 !== 1'b1 || empty1 !== 1'b1) begin
            bad++; $display("FAIL drain_empty got=%b%b want=11", empty0, empty1);
        end
    endtask

    task automatic test_empty_read();
        logic [15:0] qh;
        qh = q0;
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        total++; if (unf0 !== 1'b1 || usedw0 !== 5'd0 || q0 !== qh) begin
            bad++; $display("FAIL empty_read got unf=%b usedw=%0d q=%h want 1 0 %h", unf0, usedw0, q0, qh);
        end
        cyc(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0);
        total++; if (usedw0 !== 5'd1 || unf0 !== 1'b1 || q0 !== qh) begin
            bad++; $display("FAIL empty_rw got usedw=%0d unf=%b q=%h want 1 1 %h", usedw0, unf0, q0, qh);
        end
        total++; if (q1 !== 16'h00AA || st1 !== exp_status()) begin
            bad++; $display("FAIL empty_rw_fwft got q=%h st=%b want 00aa %b", q1, st1, exp_status());
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
            total++; if (usedw0 !== 5'd5 || q0 !== m_qreg) begin
                bad++; $display("FAIL wrap_reg[%0d] got usedw=%0d q=%h want 5 %h", i, usedw0, q0, m_qreg);
            end
            total++; if (st1 !== exp_status() || q1 !== mq[0]) begin
                bad++; $display("FAIL wrap_fwft[%0d] got st=%b q=%h want %b %h", i, st1, q1, exp_status(), mq[0]);
            end
        end
    endtask

    task automatic test_latency();
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        total++; if (q1 !== 16'hBEEF) begin bad++; $display("FAIL lat_fwft got=%h want=beef", q1); end
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        total++; if (q0 !== 16'hBEEF || empty0 !== 1'b1) begin
            bad++; $display("FAIL lat_reg got q=%h empty=%b want beef 1", q0, empty0);
        end
    endtask

    task automatic test_clear();
        logic [15:0] qh;
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        total++; if (usedw0 !== 5'd9 || ovf0 !== 1'b1) begin
            bad++; $display("FAIL clr_pre got usedw=%0d ovf=%b want 9 1", usedw0, ovf0);
        end
        qh = q0;
        cyc(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
        total++; if (usedw0 !== 5'd0 || empty0 !== 1'b1 || ovf0 !== 1'b0 || q0 !== qh) begin
            bad++; $display("FAIL clr got usedw=%0d empty=%b ovf=%b q=%h want 0 1 0 %h", usedw0, empty0, ovf0, q0, qh);
        end
        total++; if (st1 !== RESET_ST) begin bad++; $display("FAIL clr_st1 got=%b want=%b", st1, RESET_ST); end
    endtask

    task automatic test_random();
        int pw;
        logic w, r, c;
        for (int i = 0; i < 600; i++) begin
            pw = ((i / 100) % 2 == 0) ? 75 : 25;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < (100 - pw));
            c  = ($urandom_range(0, 79) == 0);
            cyc(w, r, 16'($urandom), c, 1'b0);
            total++; if (st0 !== exp_status() || q0 !== m_qreg) begin
                bad++; $display("FAIL rnd_reg[%0d] got st=%b q=%h want %b %h", i, st0, q0, exp_status(), m_qreg);
            end
            total++; if (st1 !== exp_status() || (mq.size() > 0 && q1 !== mq[0])) begin
                bad++; $display("FAIL rnd_fwft[%0d] got st=%b q=%h want %b", i, st1, q1, exp_status());
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, (i == 3), 16'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
        total++; if (st0 !== RESET_ST || q0 !== 16'h0000) begin
            bad++; $display("FAIL rst_mid_reg got st=%b q=%h want %b 0000", st0, q0, RESET_ST);
        end
        total++; if (st1 !== RESET_ST) begin bad++; $display("FAIL rst_mid_fwft got=%b want=%b", st1, RESET_ST); end
        cyc(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        total++; if (q1 !== 16'h1234) begin bad++; $display("FAIL rst_first_fwft got=%h want=1234", q1); end
        cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        total++; if (q0 !== 16'h1234 || empty0 !== 1'b1) begin
            bad++; $display("FAIL rst_first_reg got q=%h empty=%b want 1234 1", q0, empty0);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; data = 16'h0000;
        m_ovf = 1'b0; m_unf = 1'b0; m_qreg = 16'h0000;
        test_reset();
        test_fill();
        test_overflow();
        test_empty_read();
        test_wrap();
        test_latency();
        test_clear();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 Parameter ADDR_BITS, default 11, pointer width; DEPTH = 2**ADDR_BITS words (2..4096).
REQ-003 Parameter SHOWAHEAD, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_THRESH, default DEPTH-16, almost_full threshold (1..DEPTH).
REQ-005 Parameter AE_THRESH, default 16, almost_empty threshold (0..DEPTH-1).
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 clear  input  1  synchronous flush; contents discarded.
REQ-009 data  input  WIDTH  write data.
REQ-010 write  input  1  write request.
REQ-011 read  input  1  read request.
REQ-012 q  output  WIDTH  read data.
REQ-013 full  output  1  usedw == DEPTH.
REQ-014 empty  output  1  usedw == 0.
REQ-015 usedw  output  ADDR_BITS+1  stored word count, 0..DEPTH inclusive.
REQ-016 almost_full  output  1  usedw >= AF_THRESH.
REQ-017 almost_empty  output  1  usedw <= AE_THRESH.
REQ-018 overflow  output  1  sticky; a write was rejected.
REQ-019 underflow  output  1  sticky; a read was rejected.

Function
REQ-020 Storage: DEPTH x WIDTH array; wr_ptr and rd_ptr are ADDR_BITS wide and wrap modulo DEPTH without special-casing.
REQ-021 Write accepted iff write=1 and full=0 at the edge; data stored at wr_ptr, wr_ptr increments.
REQ-022 Read accepted iff read=1 and empty=0 at the edge; rd_ptr increments.
REQ-023 Flags judged on pre-edge state only: full+read+write -> read accepted, write rejected; empty+read+write -> write accepted, read rejected.
REQ-024 usedw update: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH, never below 0.
REQ-025 full, empty, almost_full, almost_empty are functions of registered usedw; they change only after a clock edge.
REQ-026 Write at edge k: empty deasserts and the word is readable from cycle k+1.
REQ-027 SHOWAHEAD=0: q is a register loaded with mem[rd_ptr] on an accepted read, visible the cycle after the read edge; held otherwise.
REQ-028 SHOWAHEAD=1: q = mem[rd_ptr] whenever empty=0; an accepted read advances to the next word the following cycle; q is don't-care while empty.
REQ-029 Rejected write sets overflow; rejected read sets underflow; both stay set until clear or reset.
REQ-030 Rejected operations change no pointer, usedw, memory word or q.
REQ-031 clear=1 overrides write and read in that cycle: pointers and usedw to 0, overflow and underflow to 0, q unchanged.
REQ-032 Memory contents are not initialised; stale words are never presented as valid data.

Reset
REQ-033 reset=1 at an edge: wr_ptr=0, rd_ptr=0, usedw=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0, registered q=0.
REQ-034 reset overrides clear, write and read; a mid-operation reset discards all contents, and the first write after reset lands at address 0.

Verification (WIDTH=16, ADDR_BITS=4, DEPTH=16, AF_THRESH=12, AE_THRESH=2)
REQ-035 Fill: 16 writes 0x0001..0x0010 -> usedw=16, full=1, almost_full at usedw=12, almost_empty cleared at usedw=3, overflow=0.
REQ-036 Overflow: 17th write while full -> usedw=16, overflow=1; drain returns 0x0001..0x0010 in order, no 0x0011.
REQ-037 Empty read: read with empty=1 -> underflow=1, usedw=0, q unchanged; simultaneous read+write on empty -> usedw=1, underflow=1.
REQ-038 Wrap: 40 interleaved write/read pairs at usedw=5 -> usedw stays 5, pointers wrap twice, data order preserved.
REQ-039 Latency: write 0xBEEF to empty FIFO then read -> SHOWAHEAD=1: q=0xBEEF before the read; SHOWAHEAD=0: q=0xBEEF the cycle after the read edge.
REQ-040 Clear/reset: clear with usedw=9, overflow=1 -> usedw=0, empty=1, overflow=0, q held; reset mid-fill -> all REQ-033 values next cycle.
